// File: rtl/ps2_key_state_if.sv
// PS/2 connector pins plus decoded key-state outputs of ps2_key_state.
// The slave modport is the decoder side; the master modport is the connector/consumer side.
interface ps2_key_state_if;
   logic       PS2_CLK;
   logic       PS2_DAT;
   logic [3:0] wasd;
   logic [3:0] arrows;
   logic [7:0] code;
   logic       code_valid;
   logic       frame_err;

   modport master (
      output PS2_CLK, PS2_DAT,
      input  wasd, arrows, code, code_valid, frame_err
   );

   modport slave (
      input  PS2_CLK, PS2_DAT,
      output wasd, arrows, code, code_valid, frame_err
   );
endinterface

// File: rtl/ps2_key_state.sv
// PS/2 set-2 receiver tracking held W/A/S/D and arrow keys; parity check under `PS2_PARITY_CHECK_EN.
// Latency: pin edge to edge pulse 3 cycles, outputs 1 cycle after the 11th pulse; no backpressure.
module ps2_key_state #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic              CLOCK,
   input logic              RESET_N,
   ps2_key_state_if.slave   bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} stateT;

   logic [2:0]    clkSync;
   logic [1:0]    datSync;
   logic          fallPulse;
   logic [3:0]    bitCnt;
   logic [9:0]    shiftReg;
   logic [TW-1:0] toCnt;
   logic [7:0]    codeReg;
   logic          codeValidReg;
   logic          frameErrReg;
   logic [3:0]    wasdReg;
   logic [3:0]    arrowsReg;
   stateT         state;
   stateT         stateNext;
   logic [3:0]    wasdNext;
   logic [3:0]    arrowsNext;
   logic [3:0]    keyMask;
   logic          isBreak;
   logic          isExt;
   logic          lastBit;
   logic          parityOk;
   logic          frameGood;
   logic          timeoutHit;
   logic          frameBad;
   logic [7:0]    rxByte;

   // Sync stages reset high so the idle-high line never looks like a falling edge.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         clkSync   <= 3'b111;
         datSync   <= 2'b11;
         fallPulse <= 1'b0;
      end else begin
         clkSync   <= {clkSync[1:0], bus.PS2_CLK};
         datSync   <= {datSync[0], bus.PS2_DAT};
         fallPulse <= clkSync[2] & ~clkSync[1];
      end
   end

   assign rxByte     = shiftReg[8:1];
   assign lastBit    = fallPulse && (bitCnt == 4'd10);
`ifdef PS2_PARITY_CHECK_EN
   assign parityOk   = ^shiftReg[9:1];
`else
   assign parityOk   = 1'b1;
`endif
   assign frameGood  = lastBit && !shiftReg[0] && datSync[1] && parityOk;
   assign timeoutHit = !fallPulse && (bitCnt != 4'd0) && (toCnt == TW'(TIMEOUT_CYCLES - 1));
   assign frameBad   = (lastBit && !frameGood) || timeoutHit;

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         bitCnt       <= 4'd0;
         shiftReg     <= 10'd0;
         toCnt        <= '0;
         codeReg      <= 8'h00;
         codeValidReg <= 1'b0;
         frameErrReg  <= 1'b0;
      end else begin
         codeValidReg <= frameGood;
         frameErrReg  <= frameBad;
         if (frameGood) codeReg <= rxByte;
         // A falling edge takes priority over a coincident timeout.
         if (fallPulse) begin
            toCnt    <= '0;
            shiftReg <= {datSync[1], shiftReg[9:1]};
            bitCnt   <= lastBit ? 4'd0 : bitCnt + 4'd1;
         end else if (timeoutHit) begin
            toCnt  <= '0;
            bitCnt <= 4'd0;
         end else if (bitCnt != 4'd0) begin
            toCnt <= toCnt + TW'(1);
         end
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         wasdReg   <= 4'd0;
         arrowsReg <= 4'd0;
      end else begin
         state     <= stateNext;
         wasdReg   <= wasdNext;
         arrowsReg <= arrowsNext;
      end
   end

   always_comb begin
      stateNext  = state;
      wasdNext   = wasdReg;
      arrowsNext = arrowsReg;
      keyMask    = 4'd0;
      isBreak    = (state == BRK) || (state == EXT_BRK);
      isExt      = (state == EXT) || (state == EXT_BRK);
      if (frameBad) begin
         stateNext = IDLE;
      end else if (frameGood) begin
         case (rxByte)
            8'hE0: stateNext = isBreak ? EXT_BRK : EXT;
            8'hF0: stateNext = isExt ? EXT_BRK : BRK;
            default: begin
               stateNext = IDLE;
               if (isExt) begin
                  case (rxByte)
                     8'h75:   keyMask = 4'b0001;
                     8'h6B:   keyMask = 4'b0010;
                     8'h72:   keyMask = 4'b0100;
                     8'h74:   keyMask = 4'b1000;
                     default: keyMask = 4'b0000;
                  endcase
                  arrowsNext = isBreak ? (arrowsReg & ~keyMask) : (arrowsReg | keyMask);
               end else begin
                  case (rxByte)
                     8'h1D:   keyMask = 4'b0001;
                     8'h1C:   keyMask = 4'b0010;
                     8'h1B:   keyMask = 4'b0100;
                     8'h23:   keyMask = 4'b1000;
                     default: keyMask = 4'b0000;
                  endcase
                  wasdNext = isBreak ? (wasdReg & ~keyMask) : (wasdReg | keyMask);
               end
            end
         endcase
      end
   end

   assign bus.wasd       = wasdReg;
   assign bus.arrows     = arrowsReg;
   assign bus.code       = codeReg;
   assign bus.code_valid = codeValidReg;
   assign bus.frame_err  = frameErrReg;
endmodule

// File: tb/tb_ps2_key_state.sv
// Randomised and directed bench for ps2_key_state against a prefix-flag/held-key reference model.
module tb_ps2_key_state;
   localparam int TO   = 200;
   localparam int HALF = 8;

   logic CLOCK   = 1'b0;
   logic RESET_N = 1'b0;

   ps2_key_state_if bus ();

   ps2_key_state #(.TIMEOUT_CYCLES(TO)) dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLOCK = ~CLOCK;

   int compared   = 0;
   int mismatched = 0;
   int cvCnt      = 0;
   int feCnt      = 0;

   logic [3:0] mWasd;
   logic [3:0] mArrows;
   logic [7:0] mCode;
   bit         mExt;
   bit         mBrk;

   logic [7:0] letterCodes [4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
   logic [7:0] arrowCodes  [4] = '{8'h75, 8'h6B, 8'h72, 8'h74};

   always @(negedge CLOCK) begin
      if (RESET_N) begin
         if (bus.code_valid) cvCnt++;
         if (bus.frame_err) feCnt++;
         if (bus.code_valid || bus.frame_err) begin
            compared++;
            if (bus.code_valid && bus.frame_err) begin
               mismatched++;
               $display("FAIL pulse_overlap: code_valid=%b frame_err=%b, required not both 1", bus.code_valid, bus.frame_err);
            end
         end
      end
   end

   task automatic model_reset();
      mWasd = 4'd0; mArrows = 4'd0; mCode = 8'h00; mExt = 0; mBrk = 0;
   endtask

   task automatic model_err();
      mExt = 0; mBrk = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      mCode = b;
      if (b == 8'hE0) mExt = 1;
      else if (b == 8'hF0) mBrk = 1;
      else begin
         for (int k = 0; k < 4; k++) begin
            if (!mExt && b == letterCodes[k]) mWasd[k] = !mBrk;
            if (mExt && b == arrowCodes[k]) mArrows[k] = !mBrk;
         end
         mExt = 0; mBrk = 0;
      end
   endtask

   // Drives nbits of an 11-bit frame; a full frame is followed by settle time.
   task automatic send_bits(input logic [7:0] b, input bit badPar, input bit badStop, input int nbits);
      logic [10:0] f;
      f[0]    = 1'b0;
      f[8:1]  = b;
      f[9]    = ~(^b) ^ badPar;
      f[10]   = ~badStop;
      for (int i = 0; i < nbits; i++) begin
         @(negedge CLOCK);
         bus.PS2_DAT = f[i];
         repeat (HALF) @(negedge CLOCK);
         bus.PS2_CLK = 1'b0;
         repeat (HALF) @(negedge CLOCK);
         bus.PS2_CLK = 1'b1;
      end
      if (nbits == 11) begin
         bus.PS2_DAT = 1'b1;
         repeat (8) @(negedge CLOCK);
      end
   endtask

   task automatic send_good(input logic [7:0] b, input string tag);
      int cv0 = cvCnt;
      int fe0 = feCnt;
      send_bits(b, 0, 0, 11);
      model_byte(b);
      compared++;
      if (cvCnt !== cv0 + 1 || feCnt !== fe0) begin
         mismatched++;
         $display("FAIL %s_pulses: code_valid %0d frame_err %0d, required 1 and 0", tag, cvCnt - cv0, feCnt - fe0);
      end
      compared++;
      if (bus.code !== mCode) begin
         mismatched++;
         $display("FAIL %s_code: got %h required %h", tag, bus.code, mCode);
      end
      compared++;
      if (bus.wasd !== mWasd || bus.arrows !== mArrows) begin
         mismatched++;
         $display("FAIL %s_keys: wasd %b arrows %b required %b %b", tag, bus.wasd, bus.arrows, mWasd, mArrows);
      end
   endtask

   task automatic test_reset();
      @(negedge CLOCK);
      compared++;
      if (bus.wasd !== 4'd0 || bus.arrows !== 4'd0 || bus.code !== 8'h00 || bus.code_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_outputs: wasd %b arrows %b code %h cv %b fe %b, required all 0", bus.wasd, bus.arrows, bus.code, bus.code_valid, bus.frame_err);
      end
      RESET_N = 1'b1;
      repeat (10) @(negedge CLOCK);
      compared++;
      if (bus.wasd !== 4'd0 || bus.code !== 8'h00 || cvCnt !== 0 || feCnt !== 0) begin
         mismatched++;
         $display("FAIL reset_idle: wasd %b code %h cv %0d fe %0d, required 0", bus.wasd, bus.code, cvCnt, feCnt);
      end
   endtask

   task automatic test_letters();
      send_good(8'h1D, "w_make");
      compared++;
      if (bus.wasd !== 4'b0001) begin
         mismatched++;
         $display("FAIL w_make_abs: got %b required 0001", bus.wasd);
      end
      send_good(8'hF0, "w_brk_prefix");
      send_good(8'h1D, "w_break");
   endtask

   task automatic test_arrows();
      send_good(8'hE0, "r_ext");
      send_good(8'h74, "r_make");
      compared++;
      if (bus.arrows !== 4'b1000) begin
         mismatched++;
         $display("FAIL r_make_abs: got %b required 1000", bus.arrows);
      end
      send_good(8'hE0, "r_ext2");
      send_good(8'hF0, "r_brk");
      send_good(8'h74, "r_break");
   endtask

   task automatic test_no_change();
      send_good(8'h75, "kp_up");
      send_good(8'hE0, "ext_a_pre");
      send_good(8'h1C, "ext_a");
      send_good(8'hAA, "bat");
      send_good(8'hFA, "ack");
   endtask

   task automatic test_parity();
      int cv0 = cvCnt;
      int fe0 = feCnt;
      send_bits(8'h23, 1, 0, 11);
`ifdef PS2_PARITY_CHECK_EN
      model_err();
      compared++;
      if (feCnt !== fe0 + 1 || cvCnt !== cv0) begin
         mismatched++;
         $display("FAIL parity_pulses: fe %0d cv %0d, required 1 and 0", feCnt - fe0, cvCnt - cv0);
      end
`else
      model_byte(8'h23);
      compared++;
      if (feCnt !== fe0 || cvCnt !== cv0 + 1) begin
         mismatched++;
         $display("FAIL parity_pulses: fe %0d cv %0d, required 0 and 1", feCnt - fe0, cvCnt - cv0);
      end
`endif
      compared++;
      if (bus.wasd !== mWasd || bus.code !== mCode) begin
         mismatched++;
         $display("FAIL parity_state: wasd %b code %h required %b %h", bus.wasd, bus.code, mWasd, mCode);
      end
   endtask

   task automatic test_bad_stop();
      int cv0 = cvCnt;
      int fe0 = feCnt;
      send_good(8'hF0, "stop_pre");
      cv0 = cvCnt; fe0 = feCnt;
      send_bits(8'h23, 0, 1, 11);
      model_err();
      compared++;
      if (feCnt !== fe0 + 1 || cvCnt !== cv0 || bus.code !== mCode) begin
         mismatched++;
         $display("FAIL bad_stop: fe %0d cv %0d code %h, required 1 0 %h", feCnt - fe0, cvCnt - cv0, bus.code, mCode);
      end
      // The dropped byte must also have cleared the pending break prefix.
      send_good(8'h1C, "after_stop");
   endtask

   task automatic test_timeout();
      int cv0 = cvCnt;
      int fe0 = feCnt;
      send_bits(8'h55, 0, 0, 5);
      repeat (TO + 20) @(negedge CLOCK);
      model_err();
      compared++;
      if (feCnt !== fe0 + 1 || cvCnt !== cv0) begin
         mismatched++;
         $display("FAIL timeout_pulse: fe %0d cv %0d, required 1 and 0", feCnt - fe0, cvCnt - cv0);
      end
      send_good(8'h1B, "post_timeout");
   endtask

   task automatic test_reset_mid_frame();
      send_good(8'h1C, "hold_a");
      send_good(8'h23, "hold_d");
      send_bits(8'h1B, 0, 0, 4);
      RESET_N = 1'b0;
      #1;
      model_reset();
      compared++;
      if (bus.wasd !== 4'd0 || bus.arrows !== 4'd0 || bus.code !== 8'h00 || bus.code_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_reset: wasd %b arrows %b code %h cv %b fe %b, required all 0", bus.wasd, bus.arrows, bus.code, bus.code_valid, bus.frame_err);
      end
      repeat (5) @(negedge CLOCK);
      RESET_N = 1'b1;
      repeat (5) @(negedge CLOCK);
      send_good(8'h1B, "post_reset");
   endtask

   task automatic test_random();
      logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74, 8'hAA, 8'hFA};
      logic [7:0] b;
      int cv0, fe0, sel;
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 12);
         b = (sel == 12) ? 8'($urandom_range(0, 255)) : pool[sel];
         if ($urandom_range(0, 7) == 0) begin
            cv0 = cvCnt; fe0 = feCnt;
            send_bits(b, 0, 1, 11);
            model_err();
            compared++;
            if (feCnt !== fe0 + 1 || cvCnt !== cv0 || bus.wasd !== mWasd || bus.arrows !== mArrows) begin
               mismatched++;
               $display("FAIL rand_err %0d: fe %0d cv %0d wasd %b arrows %b required 1 0 %b %b", n, feCnt - fe0, cvCnt - cv0, bus.wasd, bus.arrows, mWasd, mArrows);
            end
         end else begin
            send_good(b, "rand");
         end
      end
   endtask

   initial begin
      bus.PS2_CLK = 1'b1;
      bus.PS2_DAT = 1'b1;
      model_reset();
      repeat (3) @(negedge CLOCK);
      test_reset();
      test_letters();
      test_arrows();
      test_no_change();
      test_parity();
      test_bad_stop();
      test_timeout();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/ps2_key_state.md
# ps2_key_state

Receives PS/2 keyboard frames (scan code set 2), decodes make/break and extended prefixes, and maintains the live held/released state of W/A/S/D and the four cursor arrow keys. Its `wasd` and `arrows` outputs drive the movement inputs of the animation block, sampled once per animation tick. It sits between the board PS/2 connector and the game-logic layer.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 50000: number of CLOCK cycles without a PS/2 clock falling edge after which a partial frame is discarded (1 ms at 50 MHz).

**Ports**
- `CLOCK`, input, 1: system clock. One clock domain for the whole block.
- `RESET_N`, input, 1: reset, asynchronous, active-low.
- `PS2_CLK`, input, 1: PS/2 clock from the connector; asynchronous to CLOCK.
- `PS2_DAT`, input, 1: PS/2 data from the connector; asynchronous to CLOCK.
- `wasd`, output, 4: held state of the letter keys.
  - bit 0 = W, bit 1 = A, bit 2 = S, bit 3 = D.
  - 1 = held.
- `arrows`, output, 4: held state of the cursor keys.
  - bit 0 = up, bit 1 = left, bit 2 = down, bit 3 = right.
- `code`, output, 8: last accepted byte.
- `code_valid`, output, 1: one-cycle pulse when `code` updates.
- `frame_err`, output, 1: one-cycle pulse when a frame is rejected.

## Operation

**Input synchronisation**
- `PS2_CLK` and `PS2_DAT` each pass through a 2-FF synchroniser.
- A falling edge is detected as the synchronised clock going from 1 to 0.

**Frame receiver**
- Each frame is 11 bits, sampled on falling edges: start (0), 8 data bits LSB first, odd parity, stop (1).
- A 4-bit bit counter counts the bits; a 10-bit shift register holds them.
- After the 11th bit, the frame is checked: start = 0, stop = 1, and parity (see Configuration).
  - Pass: `code` is loaded and `code_valid` pulses.
  - Fail: `frame_err` pulses, the byte is dropped, and the decoder returns to IDLE.
- Idle timeout: a counter runs while the bit counter is nonzero.
  - It reaches TIMEOUT_CYCLES → the bit counter clears, the frame is discarded, and `frame_err` pulses.
  - Any falling edge reloads the counter.

**Decoder FSM:** states IDLE, EXT, BRK, EXT_BRK.
- 0xE0: IDLE→EXT; BRK→EXT_BRK; EXT stays EXT; EXT_BRK stays EXT_BRK.
- 0xF0: IDLE→BRK; EXT→EXT_BRK; BRK stays BRK; EXT_BRK stays EXT_BRK.
- Any other byte:
  - Apply the key action: make in IDLE/EXT, break in BRK/EXT_BRK.
  - Then return to IDLE.
- Non-extended keys (only in IDLE or BRK):
  - 0x1D = W, 0x1C = A, 0x1B = S, 0x23 = D.
- Extended keys (only in EXT or EXT_BRK):
  - 0x75 = up, 0x6B = left, 0x72 = down, 0x74 = right.
- No key change:
  - A non-extended keypad code (for example 0x75 without E0).
  - An extended letter code.
  - Any unlisted byte, including 0xAA and 0xFA.
- Make sets the key's bit and break clears it. Repeated makes (typematic) leave the bit at 1.
- Opposing keys can both be held: both bits are 1, with no arbitration.

## Timing

- Reset (asynchronous assert) clears everything:
  - `wasd` = 0, `arrows` = 0, `code` = 0x00, `code_valid` = 0, `frame_err` = 0.
  - FSM = IDLE; bit counter and timeout counter = 0.
- Reset mid-frame drops the partial frame. Reception restarts at the next start bit after release.
- Falling edge on `PS2_CLK` pin → edge-detect pulse 3 CLOCK cycles later.
- 11th edge-detect pulse at cycle N → at cycle N+1, `code`/`code_valid`/`frame_err` are registered and `wasd`/`arrows` update in the same cycle.
- The FSM applies a byte on the same cycle as its `code_valid`.
- `code_valid` and `frame_err` are never high together.
- If a falling edge and the timeout arrive in the same cycle, the edge wins: the bit is shifted and the counter reloads.

## Configuration

- Macro `PS2_PARITY_CHECK_EN`.
  - Defined: a frame whose data + parity bits have an even count of ones is rejected (`frame_err` pulses).
  - Not defined: the parity bit is shifted in and ignored. Only start, stop, and timeout can cause `frame_err`.

## Test plan

- Reset, then frame 0x1D → `wasd` = 4'b0001, `code` = 0x1D, one `code_valid` pulse. Then frames F0, 1D → `wasd` = 4'b0000.
- Frames E0, 74 → `arrows` = 4'b1000. Then E0, F0, 74 → `arrows` = 0.
- Frames 75 (no E0) and E0, 1C → `wasd` and `arrows` unchanged; `code_valid` pulses each byte.
- Frame 0x23 with wrong parity:
  - With `PS2_PARITY_CHECK_EN`: `frame_err` pulses, `wasd` = 0.
  - Without it: `wasd` = 4'b1000.
- 5 bits of a frame, then the line goes quiet for TIMEOUT_CYCLES → `frame_err` pulses once. A following valid 0x1B frame gives `wasd` = 4'b0100.
- Make 1C and 23 (both held), then assert `RESET_N` = 0 mid-frame → all outputs 0 immediately. After release, the next valid frame decodes correctly.
